// File: rtl/mdu_ex.sv
// mdu_ex: iterative 32x32 multiply / divide unit with HI/LO registers.
// One iteration per clock, 33-cycle busy window per operation, MTHI/MTLO
// writes while idle, flush to abandon an in-flight operation.
module mdu_ex (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;     // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [31:0] r_b;       // MUL: |multiplicand|; DIV: |divisor|
  logic        r_is_div;
  logic        r_neg_q;   // negate product / quotient at the end
  logic        r_neg_r;   // negate remainder at the end (dividend sign)
  logic        r_divz;    // divisor was zero
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_start_ok;
  logic        w_signed;
  logic        w_sgn_a;
  logic        w_sgn_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Operand decode: signed ops take magnitudes, signs are kept for the fix-up.
  always_comb begin
    w_start_ok = (r_state == S_IDLE) && start && !flush;
    w_signed   = !op[0];
    w_sgn_a    = w_signed && opA[31];
    w_sgn_b    = w_signed && opB[31];
    w_abs_a    = w_sgn_a ? (~opA + 32'd1) : opA;
    w_abs_b    = w_sgn_b ? (~opB + 32'd1) : opB;
  end

  // One shift-add (MUL) or restoring shift-subtract (DIV) step, plus final sign fix-up.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : 32'd0)};
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    // Partial remainder may need 33 bits after the shift; the difference fits in 32
    // whenever the subtraction is taken because it is then below the divisor.
    w_div_sh   = {r_acc[63:32], r_acc[31]};
    w_div_ge   = w_div_sh >= {1'b0, r_b};
    w_div_diff = w_div_sh[31:0] - r_b;
    w_div_next = {(w_div_ge ? w_div_diff : w_div_sh[31:0]), r_acc[30:0], w_div_ge};
    w_prod     = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    w_quo      = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_rem      = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: 32 RUN iterations, one FIN write-back cycle, flush aborts.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_RUN;
      S_RUN:   if (flush) w_next = S_IDLE;
               else if (r_cnt == 6'd31) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, counter, HI/LO and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_sgn_a ^ w_sgn_b;
            r_neg_r  <= op[1] && w_sgn_a;
            r_divz   <= op[1] && (opB == 32'd0);
            if (op[1]) begin
              r_acc <= {32'd0, w_abs_a};
              r_b   <= w_abs_b;
            end else begin
              r_acc <= {32'd0, w_abs_b};
              r_b   <= w_abs_a;
            end
          end else begin
            if (hi_wr) r_hi <= wdata;
            if (lo_wr) r_lo <= wdata;
          end
        end
        S_RUN: begin
          if (!flush) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FIN: begin
          if (!flush) begin
            if (r_is_div) begin
              r_lo <= r_divz ? '1 : w_quo;
              r_hi <= w_rem;
            end else begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: scoreboard bench for mdu_ex with a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mdu_ex;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_ex dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: MIPS HI/LO semantics straight from the arithmetic definition.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] ua, ub, p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      2'd0: begin p = sa * sbv; return p; end
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        p = {(ua % ub), 32'd0} | {32'd0, 32'(ua / ub)};
        return p;
      end
    endcase
  endfunction

  // Monitor: every done pulse consumes one expected result.
  logic [63:0] exp_r;
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1 expected no pending result at %0t", $time);
      end else begin
        exp_r = sb_q.pop_front();
        check("sb_hi", hi, exp_r[63:32]);
        check("sb_lo", lo, exp_r[31:0]);
      end
    end
  end

  // Issue a start at the next edge; returns at the negedge after E0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation; optionally pokes start/hi_wr/lo_wr mid-flight, which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    int n;
    int d0;
    logic [63:0] e;
    e = ref_model(o, a, b);
    sb_q.push_back(e);
    d0 = n_done;
    launch(o, a, b);
    n = 0;
    while (busy && n < 60) begin
      n++;
      if (disturb && n == 5) begin
        start = 1'b1; op = ~o; opA = $urandom; opB = $urandom;
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEADBEEF;
      end
      if (disturb && n == 6) begin
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'd33);
    m_hi = e[63:32];
    m_lo = e[31:0];
    @(negedge clk);
    check("done_pulses", 32'(n_done - d0), 32'd1);
    check("done_low_after", {31'd0, done}, 32'd0);
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
    @(negedge clk);
    hi_wr = wh; lo_wr = wl; wdata = d;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    int d0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // Directed corner operations
    run_op(2'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);
    run_op(2'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu_hi", hi, 32'h00000001);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(2'd3, 32'd7, 32'd0, 1'b0);
    check("divu_z_lo", lo, 32'hFFFFFFFF);
    check("divu_z_hi", hi, 32'd7);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'd0);
    run_op(2'd2, 32'h80000005, 32'd0, 1'b0);
    run_op(2'd1, 32'd3, 32'd5, 1'b1);
    check("disturb_lo", lo, 32'd15);

    // MTHI / MTLO
    mt_write(1'b1, 1'b0, 32'hA5A5A5A5);
    mt_write(1'b0, 1'b1, 32'h5A5A5A5A);
    mt_write(1'b1, 1'b1, 32'h01234567);

    // Flush in IDLE cancels start but keeps the MTHI write
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1; opA = 32'd9; opB = 32'd9;
    hi_wr = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; hi_wr = 1'b0;
    m_hi = 32'hCAFEF00D;
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    check("idle_flush_hi", hi, m_hi);

    // Accepted start ignores same-cycle MTLO
    @(negedge clk);
    start = 1'b1; op = 2'd1; opA = 32'd3; opB = 32'd5; lo_wr = 1'b1; wdata = 32'h11111111;
    @(negedge clk);
    start = 1'b0; lo_wr = 1'b0;
    check("start_lowr_busy", {31'd0, busy}, 32'd1);
    check("start_lowr_lo", lo, m_lo);
    // abort it via flush at the next edge
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush1_busy", {31'd0, busy}, 32'd0);

    // MULTU 3*5 flushed at E10 with a second start during busy
    d0 = n_done;
    launch(2'd1, 32'd3, 32'd5);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 2'd0; opA = 32'd100; opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);
    check("flush_no_done", 32'(n_done - d0), 32'd0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);

    // Reset at E20 of a DIV, then MTLO
    launch(2'd2, 32'd1000, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    m_hi = '0; m_lo = '0;
    mt_write(1'b0, 1'b1, 32'h12345678);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
      run_op(ro, ra, rb, ($urandom_range(0, 4) == 0));
      check("rand_hi", hi, m_hi);
      check("rand_lo", lo, m_lo);
      if ($urandom_range(0, 5) == 0) mt_write(1'($urandom), 1'b1, $urandom);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ex.md
MDU_EX -- requirements
Module: mdu_ex

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge), rst.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch operation (EX stage, one-cycle qualifier)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- opA  in  32  rs operand (multiplicand / dividend)
- opB  in  32  rt operand (multiplier / divisor)
- hi_wr  in  1  MTHI write
- lo_wr  in  1  MTLO write
- wdata  in  32  MTHI/MTLO data
- flush  in  1  abort in-flight operation (branch/jump squash)
- busy  out  1  operation in flight; drives the pipeline stall
- done  out  1  one-cycle pulse, HI/LO just updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 States SHALL be IDLE, RUN, FIN; the 6-bit iteration counter counts 0..31 in RUN.
REQ-004 IDLE with start=1 at edge E0: latch |opA|, |opB|, result signs, op; go to RUN; busy=1 from E0.
REQ-005 RUN SHALL perform one iteration per edge (E1..E32): MUL = shift-add on a 64-bit accumulator; DIV = restoring shift-subtract on a 64-bit remainder/quotient pair.
REQ-006 After the 32nd iteration (E32): go to FIN; at E33 apply sign correction, write HI/LO, go to IDLE, busy=0, done=1 for the cycle after E33 only.
REQ-007 Total latency: start at E0 -> HI/LO valid after E33; busy high for exactly 33 cycles.
REQ-008 MULT/MULTU: {HI,LO} = 64-bit product, signed or unsigned per op.
REQ-009 DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, sign follows dividend.
REQ-010 Divide by zero (both DIV and DIVU): LO=0xFFFFFFFF, HI=opA; normal latency.
REQ-011 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-012 start while busy=1 SHALL be ignored.
REQ-013 hi_wr/lo_wr in IDLE with start=0: write wdata to HI/LO at the next edge; both set writes both.
REQ-014 hi_wr/lo_wr while busy=1, or in the same cycle as an accepted start: ignored.
REQ-015 flush while busy=1: at the next edge go to IDLE, busy=0, done=0, HI/LO unchanged.
REQ-016 flush in IDLE: cancels a same-cycle start; hi_wr/lo_wr are still honoured.
REQ-017 hi/lo outputs SHALL be driven directly from registers; no combinational path from inputs.

Reset
REQ-018 rst=1 at an edge: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0.
REQ-019 rst SHALL override start, flush, hi_wr and lo_wr, including mid-operation.

Verification
REQ-020 MULT opA=0xFFFFFFFF, opB=2 -> after E33 HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulses once, busy high 33 cycles.
REQ-021 MULTU opA=0xFFFFFFFF, opB=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-022 DIV opA=0xFFFFFFF9 (-7), opB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU opA=7, opB=0 -> LO=0xFFFFFFFF, HI=7.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-024 Start MULTU 3*5, assert flush at E10 -> busy=0 after E10, no done, HI/LO keep prior values; a second start during busy does not alter the result.
REQ-025 Assert rst at E20 of a DIV -> hi=lo=0, busy=0 after E20; then lo_wr with wdata=0x12345678 -> lo=0x12345678 after the next edge.
